cpu_bus_lockstep_checker: RTL and testbench
===========================================

Name: cpu_bus_lockstep_checker

Overview:
- Receiving end of the CPU bus trace in the lockstep bench: the DUV CPU and the reference CPU each emit one bus-transaction record per access; this block collects, aligns and compares them.
- Each side is buffered in its own FIFO so small timing skews between the two models are tolerated.
- Comparisons are strictly in order. Mismatch, overflow and timeout are reported as sticky status plus counters for the bench environment.
- Synthesizable; no simulation-only constructs.

Parameters:
- ADDR_W, 16, bus address width
- DATA_W, 8, bus data width
- FIFO_DEPTH, 8, entries per side FIFO; must be a power of 2 and at least 2
- TIMEOUT, 64, maximum cycles one side may hold entries while the other side's FIFO is empty
- STOP_ON_ERR, 1, 1 = freeze comparison after the first failure

Ports:
- clk  in  1  bench clock
- rst  in  1  synchronous, active-high reset
- duv_valid  in  1  DUV record present this cycle
- duv_rw  in  1  DUV access type, 1 = read
- duv_addr  in  ADDR_W  DUV address
- duv_data  in  DATA_W  DUV data
- ref_valid / ref_rw / ref_addr / ref_data  in  1/1/ADDR_W/DATA_W  same fields for the reference CPU
- cmp_valid  out  1  one-cycle pulse: a comparison completed
- cmp_match  out  1  result of that comparison; qualified by cmp_valid
- fail  out  1  sticky: mismatch, overflow or timeout has occurred
- fail_code  out  2  00 none, 01 mismatch, 10 overflow, 11 timeout (first cause only)
- fail_addr  out  ADDR_W  DUV address of the first mismatching record
- fail_duv_data / fail_ref_data  out  DATA_W  data values of the first mismatch
- match_count  out  16  saturating count of matched records
- err_count  out  8  saturating count of mismatches

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all outputs 0, FIFOs empty, timeout counter 0, state RUN. A reset mid-operation discards all buffered records.
- Push: on a clk edge with x_valid=1, the record {rw, addr, data} is written to that side's FIFO. It is visible for comparison from the next cycle; there is no bypass path.
- Compare: when both FIFOs are non-empty and state is RUN, both heads are popped on the same edge. The record matches only if all three fields are equal. cmp_valid/cmp_match are registered and appear the cycle after the pop.
- Latency: both sides valid at edge N produce cmp_valid high during cycle N+2.
- Push and pop on the same edge to a full FIFO are legal: the pop frees the slot, and no overflow is flagged.
- Overflow: a push to a full FIFO with no simultaneous pop drops the record and sets fail_code=10.
- Timeout counter:
  - Increments each cycle in which exactly one FIFO is non-empty.
  - Clears when both FIFOs are empty or a compare occurs.
  - On reaching TIMEOUT, sets fail_code=11.
- Mismatch: increments err_count and sets fail_code=01. fail_addr and the two fail data outputs are latched on the first mismatch only.
- Match: increments match_count. match_count saturates at 0xFFFF and err_count at 0xFF.
- FSM:
  - RUN -> HALT on the first fail when STOP_ON_ERR=1.
  - With STOP_ON_ERR=0, the FSM stays in RUN and comparisons continue; fail_code still keeps only the first cause.
  - HALT: pushes are ignored, no compares occur, and counters freeze. Only rst exits HALT.
- Simultaneous fail causes on the same edge use priority mismatch > overflow > timeout.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits so full and empty are distinguished across wrap-around.

Test Plan:
- Identical streams: both sides push 20 records (e.g. read 0xFFFC data 0x00) on the same cycles -> 20 cmp_valid pulses, all cmp_match=1; match_count=20, fail=0; first pulse 2 cycles after the first push.
- Skew: the ref side lags the DUV by 5 cycles over 10 records, FIFO_DEPTH=8 -> no overflow, match_count=10, fail=0.
- Data mismatch on the 3rd record (DUV 0x3C, ref 0x3D at 0x0200) with STOP_ON_ERR=1 -> cmp_match=0 on the 3rd pulse; fail=1, fail_code=01, fail_addr=0x0200, fail_duv_data=0x3C, fail_ref_data=0x3D, err_count=1; later traffic is ignored.
- Overflow: the DUV pushes 9 records while ref stays idle -> fail_code=10 on the 9th push; the FIFO keeps 8 entries.
- Timeout: the DUV pushes 1 record and ref stays idle -> fail_code=11 exactly TIMEOUT=64 cycles later.
- Reset mid-run: assert rst for 1 cycle with 4 records buffered -> all outputs 0 on the next cycle, and a new identical stream matches from a count of 0.

Source files
------------

// File: rtl/cpu_bus_lockstep_checker.sv
// Lockstep bus-trace checker: buffers DUV and reference CPU records in per-side
// FIFOs, compares heads in order, and reports sticky fail status plus counters.
module cpu_bus_lockstep_checker #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned STOP_ON_ERR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              duv_valid,
  input  logic              duv_rw,
  input  logic [ADDR_W-1:0] duv_addr,
  input  logic [DATA_W-1:0] duv_data,
  input  logic              ref_valid,
  input  logic              ref_rw,
  input  logic [ADDR_W-1:0] ref_addr,
  input  logic [DATA_W-1:0] ref_data,
  output logic              cmp_valid,
  output logic              cmp_match,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_duv_data,
  output logic [DATA_W-1:0] fail_ref_data,
  output logic [15:0]       match_count,
  output logic [7:0]        err_count
);

  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned REC_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [REC_W-1:0]   mem_q    [2][FIFO_DEPTH];
  logic [REC_W-1:0]   mem_d    [2][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q [2];
  logic [PTR_W-1:0]   wr_ptr_d [2];
  logic [PTR_W-1:0]   rd_ptr_q [2];
  logic [PTR_W-1:0]   rd_ptr_d [2];
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               cmp_valid_q, cmp_valid_d;
  logic               cmp_match_q, cmp_match_d;
  logic               fail_q, fail_d;
  logic [1:0]         fail_code_q, fail_code_d;
  logic [ADDR_W-1:0]  fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]  fail_duv_data_q, fail_duv_data_d;
  logic [DATA_W-1:0]  fail_ref_data_q, fail_ref_data_d;
  logic [15:0]        match_count_q, match_count_d;
  logic [7:0]         err_count_q, err_count_d;

  logic [1:0]         in_valid;
  logic [REC_W-1:0]   in_rec [2];
  logic [REC_W-1:0]   head   [2];
  logic [1:0]         empty, full, push, ovf;
  logic               run, do_cmp, rec_eq, one_side, tmo_hit;
  logic [1:0]         cause;

  // Side 0 is the DUV, side 1 the reference; pointers carry an extra wrap bit.
  always_comb begin
    in_valid  = {ref_valid, duv_valid};
    in_rec[0] = {duv_rw, duv_addr, duv_data};
    in_rec[1] = {ref_rw, ref_addr, ref_data};
    for (int s = 0; s < 2; s++) begin
      empty[s] = (wr_ptr_q[s] == rd_ptr_q[s]);
      full[s]  = (wr_ptr_q[s][IDX_W-1:0] == rd_ptr_q[s][IDX_W-1:0]) &&
                 (wr_ptr_q[s][PTR_W-1] != rd_ptr_q[s][PTR_W-1]);
      head[s]  = mem_q[s][rd_ptr_q[s][IDX_W-1:0]];
    end
  end

  always_comb begin
    state_d         = state_q;
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    tmo_d           = tmo_q;
    cmp_valid_d     = 1'b0;
    cmp_match_d     = 1'b0;
    fail_d          = fail_q;
    fail_code_d     = fail_code_q;
    fail_addr_d     = fail_addr_q;
    fail_duv_data_d = fail_duv_data_q;
    fail_ref_data_d = fail_ref_data_q;
    match_count_d   = match_count_q;
    err_count_d     = err_count_q;
    push            = 2'b00;
    ovf             = 2'b00;
    tmo_hit         = 1'b0;
    cause           = 2'b00;

    run      = (state_q == ST_RUN);
    do_cmp   = run && !empty[0] && !empty[1];
    rec_eq   = (head[0] == head[1]);
    one_side = empty[0] ^ empty[1];

    // A pop on the same edge frees the slot, so a push into a full FIFO is legal then.
    for (int s = 0; s < 2; s++) begin
      push[s] = run && in_valid[s] && (!full[s] || do_cmp);
      ovf[s]  = run && in_valid[s] && full[s] && !do_cmp;
      if (do_cmp) begin
        rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
      end
      if (push[s]) begin
        mem_d[s][wr_ptr_q[s][IDX_W-1:0]] = in_rec[s];
        wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(1);
      end
    end

    if (run) begin
      if (one_side) begin
        if (tmo_q != TMO_W'(TIMEOUT)) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
        tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
      end else begin
        tmo_d = '0;
      end
    end

    if (do_cmp) begin
      cmp_valid_d = 1'b1;
      cmp_match_d = rec_eq;
      if (rec_eq) begin
        if (match_count_q != 16'hFFFF) begin
          match_count_d = match_count_q + 16'd1;
        end
      end else begin
        if (err_count_q != 8'hFF) begin
          err_count_d = err_count_q + 8'd1;
        end
        if (err_count_q == 8'd0) begin
          fail_addr_d     = head[0][DATA_W +: ADDR_W];
          fail_duv_data_d = head[0][DATA_W-1:0];
          fail_ref_data_d = head[1][DATA_W-1:0];
        end
      end
    end

    if (do_cmp && !rec_eq) begin
      cause = 2'b01;
    end else if (|ovf) begin
      cause = 2'b10;
    end else if (tmo_hit) begin
      cause = 2'b11;
    end

    if (cause != 2'b00) begin
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_code_d = cause;
      end
      if (STOP_ON_ERR != 0) begin
        state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_RUN;
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
          mem_q[s][i] <= '0;
        end
      end
      tmo_q           <= '0;
      cmp_valid_q     <= 1'b0;
      cmp_match_q     <= 1'b0;
      fail_q          <= 1'b0;
      fail_code_q     <= 2'b00;
      fail_addr_q     <= '0;
      fail_duv_data_q <= '0;
      fail_ref_data_q <= '0;
      match_count_q   <= '0;
      err_count_q     <= '0;
    end else begin
      state_q         <= state_d;
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      tmo_q           <= tmo_d;
      cmp_valid_q     <= cmp_valid_d;
      cmp_match_q     <= cmp_match_d;
      fail_q          <= fail_d;
      fail_code_q     <= fail_code_d;
      fail_addr_q     <= fail_addr_d;
      fail_duv_data_q <= fail_duv_data_d;
      fail_ref_data_q <= fail_ref_data_d;
      match_count_q   <= match_count_d;
      err_count_q     <= err_count_d;
    end
  end

  assign cmp_valid     = cmp_valid_q;
  assign cmp_match     = cmp_match_q;
  assign fail          = fail_q;
  assign fail_code     = fail_code_q;
  assign fail_addr     = fail_addr_q;
  assign fail_duv_data = fail_duv_data_q;
  assign fail_ref_data = fail_ref_data_q;
  assign match_count   = match_count_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_cpu_bus_lockstep_checker.sv
// Bench for cpu_bus_lockstep_checker: directed scenarios plus randomized
// streams, checked against a queue-based model of the checker's rules.
module tb_cpu_bus_lockstep_checker;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned REC_W   = 1 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              duv_valid, duv_rw, ref_valid, ref_rw;
  logic [ADDR_W-1:0] duv_addr, ref_addr;
  logic [DATA_W-1:0] duv_data, ref_data;
  logic              cmp_valid, cmp_match, fail;
  logic [1:0]        fail_code;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_duv_data, fail_ref_data;
  logic [15:0]       match_count;
  logic [7:0]        err_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [REC_W-1:0]  mq_duv[$];
  logic [REC_W-1:0]  mq_ref[$];
  int                m_tmo, m_match, m_err;
  bit                m_halt, m_fail, m_cv, m_cm;
  logic [1:0]        m_code;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dd, m_rd;

  cpu_bus_lockstep_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH),
    .TIMEOUT(TIMEOUT), .STOP_ON_ERR(1)
  ) dut (
    .clk(clk), .rst(rst),
    .duv_valid(duv_valid), .duv_rw(duv_rw), .duv_addr(duv_addr), .duv_data(duv_data),
    .ref_valid(ref_valid), .ref_rw(ref_rw), .ref_addr(ref_addr), .ref_data(ref_data),
    .cmp_valid(cmp_valid), .cmp_match(cmp_match), .fail(fail), .fail_code(fail_code),
    .fail_addr(fail_addr), .fail_duv_data(fail_duv_data), .fail_ref_data(fail_ref_data),
    .match_count(match_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic set_duv(input logic v, input logic [REC_W-1:0] r);
    duv_valid = v;
    {duv_rw, duv_addr, duv_data} = r;
  endtask

  task automatic set_ref(input logic v, input logic [REC_W-1:0] r);
    ref_valid = v;
    {ref_rw, ref_addr, ref_data} = r;
  endtask

  function automatic logic [REC_W-1:0] rand_rec();
    return {1'($urandom), 16'($urandom), 8'($urandom)};
  endfunction

  // Advance the model by one edge from the current inputs, then clock the DUT.
  task automatic step();
    logic [REC_W-1:0] a, b, rd, rr;
    bit cmp, one, fd, fr;
    logic [1:0] cause;
    rd = {duv_rw, duv_addr, duv_data};
    rr = {ref_rw, ref_addr, ref_data};
    m_cv = 0;
    m_cm = 0;
    if (rst) begin
      mq_duv.delete(); mq_ref.delete();
      m_tmo = 0; m_halt = 0; m_fail = 0; m_code = 0;
      m_addr = 0; m_dd = 0; m_rd = 0; m_match = 0; m_err = 0;
    end else if (!m_halt) begin
      cmp   = (mq_duv.size() > 0) && (mq_ref.size() > 0);
      one   = (mq_duv.size() > 0) != (mq_ref.size() > 0);
      fd    = duv_valid && (mq_duv.size() >= int'(DEPTH)) && !cmp;
      fr    = ref_valid && (mq_ref.size() >= int'(DEPTH)) && !cmp;
      cause = 2'd0;
      if (cmp) begin
        a = mq_duv.pop_front();
        b = mq_ref.pop_front();
        m_cv = 1;
        m_cm = (a == b);
        if (a == b) begin
          if (m_match < 65535) m_match++;
        end else begin
          if (m_err == 0) begin
            m_addr = a[DATA_W +: ADDR_W];
            m_dd   = a[DATA_W-1:0];
            m_rd   = b[DATA_W-1:0];
          end
          if (m_err < 255) m_err++;
          cause = 2'd1;
        end
      end
      if (duv_valid && !fd) mq_duv.push_back(rd);
      if (ref_valid && !fr) mq_ref.push_back(rr);
      if (cause == 0 && (fd || fr)) cause = 2'd2;
      if (one) begin
        if (m_tmo < int'(TIMEOUT)) begin
          m_tmo++;
          if (m_tmo == int'(TIMEOUT) && cause == 0) cause = 2'd3;
        end
      end else begin
        m_tmo = 0;
      end
      if (cause != 0) begin
        if (!m_fail) begin
          m_fail = 1;
          m_code = cause;
        end
        m_halt = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_duv(0, '0);
    set_ref(0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++; if (cmp_valid !== 1'b0) begin errors++; $display("FAIL reset cmp_valid got %b exp 0", cmp_valid); end
    checks++; if (cmp_match !== 1'b0) begin errors++; $display("FAIL reset cmp_match got %b exp 0", cmp_match); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset fail got %b exp 0", fail); end
    checks++; if (fail_code !== 2'b00) begin errors++; $display("FAIL reset fail_code got %b exp 00", fail_code); end
    checks++; if (fail_addr !== '0) begin errors++; $display("FAIL reset fail_addr got %h exp 0", fail_addr); end
    checks++; if (fail_duv_data !== '0 || fail_ref_data !== '0) begin errors++; $display("FAIL reset fail_data got %h/%h exp 0/0", fail_duv_data, fail_ref_data); end
    checks++; if (match_count !== 16'd0) begin errors++; $display("FAIL reset match_count got %0d exp 0", match_count); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset err_count got %0d exp 0", err_count); end
  endtask

  task automatic test_identical();
    logic [REC_W-1:0] r;
    int first, pulses;
    first = -1;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 26; i++) begin
      r = (i == 0) ? {1'b1, 16'hFFFC, 8'h00} : rand_rec();
      set_duv(i < 20, r);
      set_ref(i < 20, r);
      step();
      checks++; if (cmp_valid !== m_cv) begin errors++; $display("FAIL identical cmp_valid cyc %0d got %b exp %b", i, cmp_valid, m_cv); end
      if (m_cv) begin
        checks++; if (cmp_match !== m_cm) begin errors++; $display("FAIL identical cmp_match cyc %0d got %b exp %b", i, cmp_match, m_cm); end
      end
      if (cmp_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    checks++; if (first != 1) begin errors++; $display("FAIL identical first_pulse got %0d exp 1", first); end
    checks++; if (pulses != 20) begin errors++; $display("FAIL identical pulses got %0d exp 20", pulses); end
    checks++; if (match_count !== 16'd20) begin errors++; $display("FAIL identical match_count got %0d exp 20", match_count); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL identical fail got %b exp 0", fail); end
  endtask

  // ref_lag = 5 exercises skew; ref_lag = 7 keeps the DUV FIFO full while popping.
  task automatic test_skew(input int n, input int ref_lag);
    logic [REC_W-1:0] recs[16];
    for (int i = 0; i < n; i++) recs[i] = rand_rec();
    do_reset();
    for (int i = 0; i < n + ref_lag + 4; i++) begin
      set_duv(i < n, (i < n) ? recs[i] : '0);
      set_ref(i >= ref_lag && i < n + ref_lag, (i >= ref_lag && i < n + ref_lag) ? recs[i - ref_lag] : '0);
      step();
      checks++; if (cmp_valid !== m_cv || fail !== m_fail) begin errors++; $display("FAIL skew%0d cyc %0d cmp_valid/fail got %b/%b exp %b/%b", ref_lag, i, cmp_valid, fail, m_cv, m_fail); end
    end
    checks++; if (match_count !== 16'(n)) begin errors++; $display("FAIL skew%0d match_count got %0d exp %0d", ref_lag, match_count, n); end
    checks++; if (fail !== 1'b0 || fail_code !== 2'b00) begin errors++; $display("FAIL skew%0d fail got %b code %b exp 0 00", ref_lag, fail, fail_code); end
  endtask

  task automatic test_mismatch();
    logic [REC_W-1:0] r, rr;
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      r = {1'($urandom), 16'h0100 + 16'(i), 8'($urandom)};
      rr = r;
      if (i == 2) begin
        r  = {1'b1, 16'h0200, 8'h3C};
        rr = {1'b1, 16'h0200, 8'h3D};
      end
      set_duv(i < 9, r);
      set_ref(i < 9, rr);
      step();
      if (cmp_valid === 1'b1) begin
        pulses++;
        if (pulses == 3) begin
          checks++; if (cmp_match !== 1'b0) begin errors++; $display("FAIL mismatch third_match got %b exp 0", cmp_match); end
        end else begin
          checks++; if (cmp_match !== 1'b1) begin errors++; $display("FAIL mismatch pulse%0d match got %b exp 1", pulses, cmp_match); end
        end
      end
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL mismatch pulses got %0d exp 3", pulses); end
    checks++; if (fail !== 1'b1 || fail_code !== 2'b01) begin errors++; $display("FAIL mismatch fail got %b code %b exp 1 01", fail, fail_code); end
    checks++; if (fail_addr !== 16'h0200) begin errors++; $display("FAIL mismatch fail_addr got %h exp 0200", fail_addr); end
    checks++; if (fail_duv_data !== 8'h3C || fail_ref_data !== 8'h3D) begin errors++; $display("FAIL mismatch data got %h/%h exp 3c/3d", fail_duv_data, fail_ref_data); end
    checks++; if (err_count !== 8'd1 || match_count !== 16'd2) begin errors++; $display("FAIL mismatch counts got err %0d match %0d exp 1 2", err_count, match_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    set_ref(0, '0);
    for (int i = 0; i < 9; i++) begin
      set_duv(1, rand_rec());
      step();
      if (i < 8) begin
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL overflow early push %0d fail got %b exp 0", i, fail); end
      end
    end
    checks++; if (fail !== 1'b1 || fail_code !== 2'b10) begin errors++; $display("FAIL overflow code got %b/%b exp 1/10", fail, fail_code); end
    for (int i = 0; i < 4; i++) begin
      set_duv(1, rand_rec());
      set_ref(1, rand_rec());
      step();
      checks++; if (cmp_valid !== 1'b0) begin errors++; $display("FAIL overflow halted cmp_valid got %b exp 0", cmp_valid); end
    end
    checks++; if (fail_code !== 2'b10 || err_count !== 8'd0 || match_count !== 16'd0) begin errors++; $display("FAIL overflow frozen got code %b err %0d match %0d exp 10 0 0", fail_code, err_count, match_count); end
  endtask

  task automatic test_timeout();
    int k;
    do_reset();
    set_duv(1, rand_rec());
    step();
    set_duv(0, '0);
    k = 1;
    while (k <= 200) begin
      step();
      if (fail === 1'b1) break;
      k++;
    end
    checks++; if (k != int'(TIMEOUT)) begin errors++; $display("FAIL timeout latency got %0d exp %0d", k, TIMEOUT); end
    checks++; if (fail_code !== 2'b11) begin errors++; $display("FAIL timeout code got %b exp 11", fail_code); end
  endtask

  task automatic test_reset_midrun();
    logic [REC_W-1:0] r;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_duv(1, rand_rec());
      step();
    end
    set_duv(0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({cmp_valid, cmp_match, fail, fail_code} !== 5'b0 || match_count !== 16'd0 || err_count !== 8'd0 || fail_addr !== '0) begin
      errors++; $display("FAIL midrun reset outputs got cv %b f %b code %b mc %0d ec %0d exp all 0", cmp_valid, fail, fail_code, match_count, err_count);
    end
    for (int i = 0; i < 10; i++) begin
      r = rand_rec();
      set_duv(i < 6, r);
      set_ref(i < 6, r);
      step();
    end
    checks++; if (match_count !== 16'd6 || fail !== 1'b0) begin errors++; $display("FAIL midrun restream got match %0d fail %b exp 6 0", match_count, fail); end
  endtask

  task automatic test_random();
    logic [REC_W-1:0] recs[30];
    bit bad[30];
    int di, ri, pd, pr;
    for (int run = 0; run < 5; run++) begin
      for (int i = 0; i < 30; i++) begin
        recs[i] = rand_rec();
        bad[i]  = (run > 0) && ($urandom_range(19) == 0);
      end
      pd = 30 + int'($urandom_range(60));
      pr = 30 + int'($urandom_range(60));
      di = 0;
      ri = 0;
      do_reset();
      for (int c = 0; c < 100; c++) begin
        if (di < 30 && int'($urandom_range(99)) < pd) begin
          set_duv(1, recs[di]);
          di++;
        end else begin
          set_duv(0, '0);
        end
        if (ri < 30 && int'($urandom_range(99)) < pr) begin
          set_ref(1, bad[ri] ? (recs[ri] ^ REC_W'(1)) : recs[ri]);
          ri++;
        end else begin
          set_ref(0, '0);
        end
        step();
        checks++; if (cmp_valid !== m_cv) begin errors++; $display("FAIL rand%0d cmp_valid cyc %0d got %b exp %b", run, c, cmp_valid, m_cv); end
        if (m_cv) begin
          checks++; if (cmp_match !== m_cm) begin errors++; $display("FAIL rand%0d cmp_match cyc %0d got %b exp %b", run, c, cmp_match, m_cm); end
        end
        checks++; if (fail !== m_fail || fail_code !== m_code) begin errors++; $display("FAIL rand%0d status cyc %0d got %b/%b exp %b/%b", run, c, fail, fail_code, m_fail, m_code); end
        checks++; if (match_count !== 16'(m_match) || err_count !== 8'(m_err)) begin errors++; $display("FAIL rand%0d counts cyc %0d got %0d/%0d exp %0d/%0d", run, c, match_count, err_count, m_match, m_err); end
        checks++; if (fail_addr !== m_addr || fail_duv_data !== m_dd || fail_ref_data !== m_rd) begin errors++; $display("FAIL rand%0d capture cyc %0d got %h %h %h exp %h %h %h", run, c, fail_addr, fail_duv_data, fail_ref_data, m_addr, m_dd, m_rd); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_duv(0, '0);
    set_ref(0, '0);
    test_reset();
    test_identical();
    test_skew(10, 5);
    test_skew(12, 7);
    test_mismatch();
    test_overflow();
    test_timeout();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
